sdram_aref_ctrl: RTL and testbench
==================================

Name: sdram_aref_ctrl

Overview:
- Parametrised SDRAM auto-refresh engine: generates periodic refresh tokens after init and tracks postponed refreshes as a debt counter.
- Issues PRE-all then one or more AREF commands when granted by the command arbiter.
- Sits beside the init, write and read engines; its aref_cmd/aref_addr are muxed onto the SDRAM bus by the arbiter.
- Beyond a fixed single-refresh block: configurable timings, refresh postponement up to MAX_DEBT, an urgency flag, burst catch-up mode and an overflow error flag.

Parameters:
REF_INTERVAL, 1500, sclk cycles per refresh token
T_RP, 2, cycles from PRE to AREF (>=1)
T_RFC, 7, cycles from AREF to next command (>=1)
MAX_DEBT, 8, max owed refreshes (>=1)
URGENT_LVL, 6, debt at which urgency asserts (1..MAX_DEBT)
ADDR_W, 12, SDRAM address width (>=11)
DW, clog2(MAX_DEBT+1), debt counter width (derived, localparam)

Ports:
sclk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
init_done  in  1  SDRAM init complete; low holds timer/debt cleared
aref_en  in  1  arbiter grant, sampled only in IDLE
burst_all  in  1  sampled with grant: 1 = refresh until debt 0, 0 = one refresh
aref_req  out  1  refresh owed, engine idle
aref_urgent  out  1  debt >= URGENT_LVL
aref_busy  out  1  sequence in progress
aref_end  out  1  one-cycle pulse, sequence finished
aref_cmd  out  4  {CS_n,RAS_n,CAS_n,WE_n}
aref_addr  out  ADDR_W  constant, A10=1, all other bits 0
aref_debt  out  DW  owed refresh count
aref_overflow  out  1  sticky: token lost at saturated debt

Behaviour:
- Reset values: aref_cmd=NOP 4'b0111, all 1-bit outputs 0, aref_debt=0; FSM IDLE. Reset mid-sequence aborts immediately.
- Tick timer: counts 0..REF_INTERVAL-1 while init_done=1; on REF_INTERVAL-1 it wraps to 0 and emits a 1-cycle tick. init_done=0 forces count 0, no tick.
- Debt: +1 on tick, -1 in each cycle aref_cmd=AREF. Both in the same cycle -> unchanged.
- Debt saturates at MAX_DEBT. Tick at MAX_DEBT with no decrement -> aref_overflow set; cleared only by rst_n.
- init_done=0 clears debt next cycle; an in-flight sequence still completes, and its AREF decrement is suppressed at 0.
- aref_req = (state==IDLE) && (debt!=0); aref_urgent = debt >= URGENT_LVL. Both are decoded from registers, glitch-free.
- FSM states and transitions:
  - IDLE: aref_en && debt!=0 -> PRE, latch burst_all; aref_en with debt 0 ignored.
  - PRE: 1 cycle.
  - WAIT_RP: T_RP-1 cycles (skipped if T_RP=1).
  - AREF: 1 cycle.
  - WAIT_RFC: T_RFC-1 cycles, then AREF again if latched burst && debt!=0, else DONE. No repeat PRE within a burst.
  - DONE: 1 cycle, then IDLE.
- aref_cmd is registered and equals PRE (4'b0010) in PRE, AREF (4'b0001) in AREF, NOP otherwise.
- aref_busy=1 in every state except IDLE; aref_end=1 only in DONE.
- Default single-refresh timeline, grant sampled at cycle 0: PRE c1, NOP c2, AREF c3, NOP c4-c9, aref_end c10, aref_req earliest c11.
- aref_en while busy is ignored. Tick during a sequence increments debt, so a burst may extend.

Decomposition:
- Package sdram_pkg: SDRAM command encodings (NOP/PRE/AREF/ACT/RD/WR/MRS), refresh FSM state enum, clog2 function.
- One sub-module, sdram_ref_tick: parametrised interval counter with init_done gating and tick output.
- Debt counter and FSM stay in sdram_aref_ctrl.

Test Plan:
- Reset, init_done=1, REF_INTERVAL=100, no grant -> first tick at cycle 100; debt=1, aref_req=1, cmd stays NOP.
- debt=1, pulse aref_en with burst_all=0 -> PRE c1, AREF c3, aref_end c10, debt 0, aref_req stays 0.
- Withhold grant for 6 ticks -> debt=6, aref_urgent=1; grant with burst_all=1 -> 1 PRE + 6 AREF spaced 7 cycles, single aref_end, debt 0.
- Withhold grant for 9 ticks (MAX_DEBT=8) -> debt holds 8, aref_overflow=1, stays set through later refreshes.
- Align tick with the AREF cycle -> debt unchanged that cycle; drop init_done mid-sequence -> sequence completes, debt 0, timer restarts at 0.
- Assert rst_n=0 during WAIT_RFC -> outputs return to reset values asynchronously; aref_en with debt 0 -> no command.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, refresh FSM states, clog2 helper.
package sdram_pkg;

    // {CS_n, RAS_n, CAS_n, WE_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_RD   = 4'b0101;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_MRS  = 4'b0000;

    // Refresh FSM states
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PRE      = 3'd1;
    localparam logic [2:0] ST_WAIT_RP  = 3'd2;
    localparam logic [2:0] ST_AREF     = 3'd3;
    localparam logic [2:0] ST_WAIT_RFC = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    // Ceiling log2, usable in parameter expressions
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/sdram_ref_tick.sv
// Refresh interval timer: counts 0..REF_INTERVAL-1 while init is done and
// flags the wrap cycle as a one-cycle tick. Held at zero until init completes.
module sdram_ref_tick
    import sdram_pkg::*;
#(
    parameter int REF_INTERVAL = 1500
) (
    input  logic i_sclk,
    input  logic i_rst_n,
    input  logic i_init_done,
    output logic o_tick
);

    localparam int CW = (clog2(REF_INTERVAL + 1) < 1) ? 1 : clog2(REF_INTERVAL + 1);

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == CW'(REF_INTERVAL - 1));
    assign o_tick = i_init_done && w_wrap;

    // Interval counter, forced to zero while init is incomplete
    always_ff @(posedge i_sclk or negedge i_rst_n) begin
        if (!i_rst_n)          r_cnt <= '0;
        else if (!i_init_done) r_cnt <= '0;
        else if (w_wrap)       r_cnt <= '0;
        else                   r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/sdram_aref_ctrl.sv
// SDRAM auto-refresh engine: accumulates refresh debt from the interval timer
// and, when granted, issues PRE-all followed by one AREF (or a burst of AREFs
// until the debt is cleared). All outputs are registered.
module sdram_aref_ctrl
    import sdram_pkg::*;
#(
    parameter int REF_INTERVAL = 1500,
    parameter int T_RP         = 2,
    parameter int T_RFC        = 7,
    parameter int MAX_DEBT     = 8,
    parameter int URGENT_LVL   = 6,
    parameter int ADDR_W       = 12,
    localparam int DW          = clog2(MAX_DEBT + 1)
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic              init_done,
    input  logic              aref_en,
    input  logic              burst_all,
    output logic              aref_req,
    output logic              aref_urgent,
    output logic              aref_busy,
    output logic              aref_end,
    output logic [3:0]        aref_cmd,
    output logic [ADDR_W-1:0] aref_addr,
    output logic [DW-1:0]     aref_debt,
    output logic              aref_overflow
);

    localparam int TMAX = (T_RP > T_RFC) ? T_RP : T_RFC;
    localparam int WC_W = clog2(TMAX + 1) + 1;

    logic [2:0]      r_state, w_state_nxt;
    logic [WC_W-1:0] r_wcnt, w_wcnt_nxt;
    logic            r_burst, w_burst_nxt;
    logic [DW-1:0]   r_debt, w_debt_nxt;
    logic            r_ovf, w_ovf_nxt;
    logic [3:0]      r_cmd;
    logic            r_req, r_urgent, r_busy, r_end;
    logic            w_tick, w_dec, w_again;

    sdram_ref_tick #(
        .REF_INTERVAL (REF_INTERVAL)
    ) u_tick (
        .i_sclk      (sclk),
        .i_rst_n     (rst_n),
        .i_init_done (init_done),
        .o_tick      (w_tick)
    );

    // The AREF cycle pays one refresh; never drop below zero (debt may have
    // been cleared by init_done falling mid-sequence).
    assign w_dec = (r_state == ST_AREF) && (r_debt != '0);

    // Repeat decision looks at next-cycle debt so the AREF decrement is seen
    // even when T_RFC=1 leaves no wait state in between.
    assign w_again = r_burst && (w_debt_nxt != '0);

    // Debt bookkeeping: tick adds, AREF subtracts, simultaneous events cancel
    always_comb begin
        w_debt_nxt = r_debt;
        w_ovf_nxt  = r_ovf;
        if (!init_done) begin
            w_debt_nxt = '0;
        end else if (w_tick && !w_dec) begin
            if (r_debt == DW'(MAX_DEBT)) w_ovf_nxt  = 1'b1;
            else                         w_debt_nxt = r_debt + 1'b1;
        end else if (!w_tick && w_dec) begin
            w_debt_nxt = r_debt - 1'b1;
        end
    end

    // Sequence FSM: PRE -> tRP -> AREF -> tRFC -> (AREF ...) -> DONE
    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        w_burst_nxt = r_burst;
        case (r_state)
            ST_IDLE: begin
                if (aref_en && (r_debt != '0)) begin
                    w_state_nxt = ST_PRE;
                    w_burst_nxt = burst_all;
                end
            end
            ST_PRE: begin
                if (T_RP == 1) begin
                    w_state_nxt = ST_AREF;
                end else begin
                    w_state_nxt = ST_WAIT_RP;
                    w_wcnt_nxt  = WC_W'(T_RP - 2);
                end
            end
            ST_WAIT_RP: begin
                if (r_wcnt == '0) w_state_nxt = ST_AREF;
                else              w_wcnt_nxt  = r_wcnt - 1'b1;
            end
            ST_AREF: begin
                if (T_RFC == 1) begin
                    w_state_nxt = w_again ? ST_AREF : ST_DONE;
                end else begin
                    w_state_nxt = ST_WAIT_RFC;
                    w_wcnt_nxt  = WC_W'(T_RFC - 2);
                end
            end
            ST_WAIT_RFC: begin
                if (r_wcnt == '0) w_state_nxt = w_again ? ST_AREF : ST_DONE;
                else              w_wcnt_nxt  = r_wcnt - 1'b1;
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // State, debt and registered output decode (outputs follow next state)
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_wcnt   <= '0;
            r_burst  <= 1'b0;
            r_debt   <= '0;
            r_ovf    <= 1'b0;
            r_cmd    <= CMD_NOP;
            r_req    <= 1'b0;
            r_urgent <= 1'b0;
            r_busy   <= 1'b0;
            r_end    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_wcnt   <= w_wcnt_nxt;
            r_burst  <= w_burst_nxt;
            r_debt   <= w_debt_nxt;
            r_ovf    <= w_ovf_nxt;
            r_cmd    <= (w_state_nxt == ST_PRE)  ? CMD_PRE  :
                        (w_state_nxt == ST_AREF) ? CMD_AREF : CMD_NOP;
            r_req    <= (w_state_nxt == ST_IDLE) && (w_debt_nxt != '0);
            r_urgent <= (w_debt_nxt >= DW'(URGENT_LVL));
            r_busy   <= (w_state_nxt != ST_IDLE);
            r_end    <= (w_state_nxt == ST_DONE);
        end
    end

    assign aref_cmd      = r_cmd;
    assign aref_addr     = ADDR_W'(1 << 10);
    assign aref_debt     = r_debt;
    assign aref_overflow = r_ovf;
    assign aref_req      = r_req;
    assign aref_urgent   = r_urgent;
    assign aref_busy     = r_busy;
    assign aref_end      = r_end;

endmodule

// File: tb/tb_sdram_aref_ctrl.sv
// Directed bench for sdram_aref_ctrl with REF_INTERVAL=100 and default timings.
// Edge En = n-th rising edge after init_done rises; ticks land on E100, E200, ...
module tb_sdram_aref_ctrl;

    logic        sclk, rst_n, init_done, aref_en, burst_all;
    logic        aref_req, aref_urgent, aref_busy, aref_end, aref_overflow;
    logic [3:0]  aref_cmd;
    logic [11:0] aref_addr;
    logic [3:0]  aref_debt;

    int n_vec = 0;
    int n_err = 0;
    int pres, arefs, ends, badsp, first_aref, nonnop, busy_seen;

    sdram_aref_ctrl #(
        .REF_INTERVAL (100),
        .T_RP         (2),
        .T_RFC        (7),
        .MAX_DEBT     (8),
        .URGENT_LVL   (6),
        .ADDR_W       (12)
    ) dut (
        .sclk          (sclk),
        .rst_n         (rst_n),
        .init_done     (init_done),
        .aref_en       (aref_en),
        .burst_all     (burst_all),
        .aref_req      (aref_req),
        .aref_urgent   (aref_urgent),
        .aref_busy     (aref_busy),
        .aref_end      (aref_end),
        .aref_cmd      (aref_cmd),
        .aref_addr     (aref_addr),
        .aref_debt     (aref_debt),
        .aref_overflow (aref_overflow)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge sclk);
        #1;
    endtask

    // Sample n cycles starting at c1 of a grant; grant is dropped after c1
    task automatic run_window(input int n, output int o_pres, output int o_arefs,
                              output int o_ends, output int o_badsp, output int o_first);
        int last;
        o_pres = 0; o_arefs = 0; o_ends = 0; o_badsp = 0; o_first = -1; last = -1;
        for (int i = 1; i <= n; i++) begin
            step(1);
            if (i == 1) aref_en = 1'b0;
            if (aref_cmd == 4'b0010) o_pres++;
            if (aref_cmd == 4'b0001) begin
                if (last >= 0 && (i - last) != 7) o_badsp++;
                if (o_first < 0) o_first = i;
                last = i;
                o_arefs++;
            end
            if (aref_end) o_ends++;
        end
    endtask

    initial begin
        rst_n = 1'b0; init_done = 1'b0; aref_en = 1'b0; burst_all = 1'b0;
        step(2);
        chk("rst_cmd",    32'(aref_cmd), 32'h7);
        chk("rst_req",    32'(aref_req), 32'h0);
        chk("rst_urgent", 32'(aref_urgent), 32'h0);
        chk("rst_busy",   32'(aref_busy), 32'h0);
        chk("rst_end",    32'(aref_end), 32'h0);
        chk("rst_debt",   32'(aref_debt), 32'h0);
        chk("rst_ovf",    32'(aref_overflow), 32'h0);
        chk("addr",       32'(aref_addr), 32'h400);

        rst_n = 1'b1; init_done = 1'b1;
        step(99);                                   // E99
        chk("pretick_debt", 32'(aref_debt), 32'h0);
        chk("pretick_req",  32'(aref_req), 32'h0);
        step(1);                                    // E100: first tick
        chk("tick1_debt", 32'(aref_debt), 32'h1);
        chk("tick1_req",  32'(aref_req), 32'h1);
        chk("tick1_cmd",  32'(aref_cmd), 32'h7);
        chk("tick1_busy", 32'(aref_busy), 32'h0);

        // single refresh, grant sampled at E101
        aref_en = 1'b1; burst_all = 1'b0;
        step(1); aref_en = 1'b0;
        chk("s_c1_cmd",  32'(aref_cmd), 32'h2);
        chk("s_c1_busy", 32'(aref_busy), 32'h1);
        chk("s_c1_req",  32'(aref_req), 32'h0);
        step(1); chk("s_c2_cmd", 32'(aref_cmd), 32'h7);
        step(1); chk("s_c3_cmd", 32'(aref_cmd), 32'h1);
        step(1); chk("s_c4_cmd", 32'(aref_cmd), 32'h7);
        chk("s_c4_debt", 32'(aref_debt), 32'h0);
        step(5); chk("s_c9_end", 32'(aref_end), 32'h0);
        step(1); chk("s_c10_end", 32'(aref_end), 32'h1);
        chk("s_c10_busy", 32'(aref_busy), 32'h1);
        step(1);                                    // E111
        chk("s_c11_end",  32'(aref_end), 32'h0);
        chk("s_c11_busy", 32'(aref_busy), 32'h0);
        chk("s_c11_req",  32'(aref_req), 32'h0);

        // accumulate 6 ticks, then burst
        step(489);                                  // E600
        chk("d5_debt",   32'(aref_debt), 32'h5);
        chk("d5_urgent", 32'(aref_urgent), 32'h0);
        step(100);                                  // E700
        chk("d6_debt",   32'(aref_debt), 32'h6);
        chk("d6_urgent", 32'(aref_urgent), 32'h1);
        chk("d6_req",    32'(aref_req), 32'h1);
        aref_en = 1'b1; burst_all = 1'b1;
        run_window(50, pres, arefs, ends, badsp, first_aref);   // to E750
        chk("b6_pre",     32'(pres), 32'd1);
        chk("b6_aref",    32'(arefs), 32'd6);
        chk("b6_end",     32'(ends), 32'd1);
        chk("b6_spacing", 32'(badsp), 32'd0);
        chk("b6_first",   32'(first_aref), 32'd3);
        chk("b6_debt",    32'(aref_debt), 32'h0);
        chk("b6_urgent",  32'(aref_urgent), 32'h0);
        chk("b6_busy",    32'(aref_busy), 32'h0);

        // saturate: ticks at E800..E1600
        step(750);                                  // E1500
        chk("sat_debt8", 32'(aref_debt), 32'h8);
        chk("sat_ovf0",  32'(aref_overflow), 32'h0);
        step(100);                                  // E1600
        chk("sat_debt_hold", 32'(aref_debt), 32'h8);
        chk("sat_ovf1",      32'(aref_overflow), 32'h1);
        aref_en = 1'b1; burst_all = 1'b1;
        run_window(60, pres, arefs, ends, badsp, first_aref);   // to E1660
        chk("b8_pre",     32'(pres), 32'd1);
        chk("b8_aref",    32'(arefs), 32'd8);
        chk("b8_end",     32'(ends), 32'd1);
        chk("b8_spacing", 32'(badsp), 32'd0);
        chk("b8_debt",    32'(aref_debt), 32'h0);
        chk("b8_ovf",     32'(aref_overflow), 32'h1);

        // AREF decrement on E1800 coincides with the tick
        step(136);                                  // E1796
        chk("al_debt_pre", 32'(aref_debt), 32'h1);
        aref_en = 1'b1; burst_all = 1'b0;
        step(1); aref_en = 1'b0;                    // E1797 c1
        chk("al_c1_cmd", 32'(aref_cmd), 32'h2);
        step(2);                                    // E1799 c3
        chk("al_c3_cmd", 32'(aref_cmd), 32'h1);
        step(1);                                    // E1800
        chk("al_debt_same", 32'(aref_debt), 32'h1);
        step(7);                                    // E1807 c11
        chk("al_busy", 32'(aref_busy), 32'h0);
        chk("al_req",  32'(aref_req), 32'h1);

        // init_done drops mid-sequence
        aref_en = 1'b1; burst_all = 1'b1;
        step(1); aref_en = 1'b0;                    // E1808 c1
        chk("id_c1_cmd", 32'(aref_cmd), 32'h2);
        step(1); init_done = 1'b0;                  // E1809 c2
        step(1);                                    // E1810 c3
        chk("id_c3_cmd",  32'(aref_cmd), 32'h1);
        chk("id_c3_debt", 32'(aref_debt), 32'h0);
        step(7);                                    // E1817 c10
        chk("id_end", 32'(aref_end), 32'h1);
        step(1);                                    // E1818
        chk("id_busy", 32'(aref_busy), 32'h0);
        chk("id_req",  32'(aref_req), 32'h0);
        chk("id_debt", 32'(aref_debt), 32'h0);
        chk("id_ovf_sticky", 32'(aref_overflow), 32'h1);
        init_done = 1'b1;
        step(99);
        chk("rs_debt0", 32'(aref_debt), 32'h0);
        step(1);
        chk("rs_debt1", 32'(aref_debt), 32'h1);

        // async reset inside WAIT_RFC
        aref_en = 1'b1; burst_all = 1'b0;
        step(1); aref_en = 1'b0;
        step(5);                                    // c6
        chk("ar_busy_before", 32'(aref_busy), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_cmd",  32'(aref_cmd), 32'h7);
        chk("ar_busy", 32'(aref_busy), 32'h0);
        chk("ar_debt", 32'(aref_debt), 32'h0);
        chk("ar_ovf",  32'(aref_overflow), 32'h0);
        chk("ar_req",  32'(aref_req), 32'h0);
        #2 rst_n = 1'b1;

        // grant with zero debt is ignored
        aref_en = 1'b1;
        nonnop = 0; busy_seen = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (aref_cmd != 4'b0111) nonnop++;
            if (aref_busy) busy_seen++;
        end
        aref_en = 1'b0;
        chk("z_nonnop", 32'(nonnop), 32'd0);
        chk("z_busy",   32'(busy_seen), 32'd0);
        chk("z_debt",   32'(aref_debt), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
